// File: rtl/instruction_align_buffer_if.sv
// Bundle of fetch, redirect and decode-handshake signals for instruction_align_buffer.
`default_nettype none

interface instruction_align_buffer_if;
   logic        memRequest;
   logic [31:0] memAddress;
   logic        memReady;
   logic [31:0] memData;
   logic        redirect;
   logic [31:0] redirectPc;
   logic        outValid;
   logic        outReady;
   logic [31:0] outInstruction;
   logic [31:0] outPc;
   logic        outIsCompact;

   modport master (
      output memRequest, memAddress, outValid, outInstruction, outPc, outIsCompact,
      input  memReady, memData, redirect, redirectPc, outReady
   );

   modport slave (
      input  memRequest, memAddress, outValid, outInstruction, outPc, outIsCompact,
      output memReady, memData, redirect, redirectPc, outReady
   );
endinterface

`default_nettype wire

// File: rtl/instruction_align_buffer.sv
// Splits a word-aligned RV32C fetch stream into whole 16/32-bit instructions
// using a three-halfword holding buffer.
`default_nettype none

module instruction_align_buffer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                        clk,
   input  logic                        reset,
   instruction_align_buffer_if.master  bus
);

   logic [47:0] hold_q, hold_d;
   logic [1:0]  count_q, count_d;
   logic [31:0] bufPc_q, bufPc_d;
   logic [31:0] fetchAddr_q, fetchAddr_d;
   logic        skipLow_q, skipLow_d;

   logic [15:0] slot0;
   logic        slot0Compact;
   logic        fetchDone;
   logic [1:0]  consumed;
   logic [1:0]  remCount;
   logic [47:0] rem;
   logic [31:0] app;
   logic [1:0]  appCount;
   logic        unused_pcBit0;

   assign unused_pcBit0 = bus.redirectPc[0];

   assign slot0        = hold_q[15:0];
   assign slot0Compact = (slot0[1:0] != 2'b11);

   assign bus.outValid       = reset && (count_q != 2'd0) && (slot0Compact || count_q >= 2'd2);
   assign bus.outIsCompact   = reset && slot0Compact;
   assign bus.outInstruction = slot0Compact ? {16'h0000, slot0} : hold_q[31:0];
   assign bus.outPc          = bufPc_q;
   assign bus.memRequest     = reset && !bus.redirect && (count_q <= 2'd1);
   assign bus.memAddress     = fetchAddr_q;

   assign fetchDone = bus.memRequest && bus.memReady;

   always_comb begin
      consumed = 2'd0;
      if (bus.outValid && bus.outReady)
         consumed = slot0Compact ? 2'd1 : 2'd2;

      case (consumed)
         2'd1:    rem = {16'h0000, hold_q[47:16]};
         2'd2:    rem = {32'h0000_0000, hold_q[47:32]};
         default: rem = hold_q;
      endcase
      remCount = count_q - consumed;

      if (skipLow_q) begin
         app      = {16'h0000, bus.memData[31:16]};
         appCount = 2'd1;
      end else begin
         app      = bus.memData;
         appCount = 2'd2;
      end

      hold_d      = rem;
      count_d     = remCount;
      bufPc_d     = bufPc_q + {29'h0, consumed, 1'b0};
      fetchAddr_d = fetchAddr_q;
      skipLow_d   = skipLow_q;

      // A fetch only happens with count <= 1, so the remainder is at most one halfword.
      if (fetchDone) begin
         fetchAddr_d = fetchAddr_q + 32'd4;
         skipLow_d   = 1'b0;
         count_d     = remCount + appCount;
         if (remCount == 2'd0)
            hold_d = {16'h0000, app};
         else
            hold_d = {app, rem[15:0]};
      end

      if (bus.redirect) begin
         hold_d      = hold_q;
         count_d     = 2'd0;
         bufPc_d     = {bus.redirectPc[31:1], 1'b0};
         fetchAddr_d = {bus.redirectPc[31:2], 2'b00};
         skipLow_d   = bus.redirectPc[1];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         hold_q      <= '0;
         count_q     <= 2'd0;
         bufPc_q     <= {RESET_PC[31:1], 1'b0};
         fetchAddr_q <= {RESET_PC[31:2], 2'b00};
         skipLow_q   <= RESET_PC[1];
      end else begin
         hold_q      <= hold_d;
         count_q     <= count_d;
         bufPc_q     <= bufPc_d;
         fetchAddr_q <= fetchAddr_d;
         skipLow_q   <= skipLow_d;
      end
   end

endmodule

`default_nettype wire
